// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizes and pin-bit indices for the Tiny Tapeout FIFO tile
package fifo_pkg;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   localparam int WR_EN_BIT = 0;
   localparam int RD_EN_BIT = 1;
   localparam int FULL_BIT  = 2;
   localparam int EMPTY_BIT = 3;
   localparam int AFULL_BIT = 4;
   localparam int OVF_BIT   = 5;
   localparam int UDF_BIT   = 6;

   localparam logic [7:0] UIO_OE_MASK = 8'b0111_1100;

endpackage

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - generic synchronous FIFO: storage, pointers, occupancy count and flags
module fifo_sync
   import fifo_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_req,
   input  logic             rd_req,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic             almost_full
);

   localparam logic [AW:0] CNT_FULL  = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_AFULL = (AW+1)'(DEPTH - 2);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             push, pop;

   always_comb begin
      full        = (count_q == CNT_FULL);
      empty       = (count_q == '0);
      almost_full = (count_q >= CNT_AFULL);
      // A full FIFO still accepts a write when a read frees a slot in the same cycle.
      pop         = rd_req & ~empty;
      push        = wr_req & (~full | pop);

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      rdata_d  = rdata_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         rdata_d  = mem_q[rd_ptr_q];
      end
      if (push && !pop) begin
         count_d = count_q + (AW+1)'(1);
      end else if (pop && !push) begin
         count_d = count_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdata_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         rdata_q  <= rdata_d;
      end
   end

   // Storage is never cleared; reset only blocks a write landing in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/tt_um_sync_fifo.sv
// rtl/tt_um_sync_fifo.sv - Tiny Tapeout tile wrapping a 16x8 FIFO with sticky error flags
module tt_um_sync_fifo
   import fifo_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   // The pin is named rst_n by the tile template but resets when high.
   logic rst;
   logic wr_req, rd_req;
   logic full, empty, almost_full;
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;
   logic unused_pins;

   assign rst         = rst_n;
   assign wr_req      = ena & uio_in[WR_EN_BIT];
   assign rd_req      = ena & uio_in[RD_EN_BIT];
   assign unused_pins = &{1'b0, uio_in[7:2]};

   fifo_sync u_fifo (
      .clk         (clk),
      .rst         (rst),
      .wr_req      (wr_req),
      .rd_req      (rd_req),
      .wdata       (ui_in),
      .rdata       (uo_out),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full)
   );

   always_comb begin
      overflow_d  = overflow_q  | (wr_req & full & ~rd_req);
      underflow_d = underflow_q | (rd_req & empty);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_comb begin
      uio_out            = '0;
      uio_out[FULL_BIT]  = full;
      uio_out[EMPTY_BIT] = empty;
      uio_out[AFULL_BIT] = almost_full;
      uio_out[OVF_BIT]   = overflow_q;
      uio_out[UDF_BIT]   = underflow_q;
   end

   assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_sync_fifo.sv
// tb/tb_tt_um_sync_fifo.sv - scoreboard bench for tt_um_sync_fifo against a queue-based model
module tb_tt_um_sync_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   always #5 clk = ~clk;

   tt_um_sync_fifo dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   typedef struct {
      logic       has_data;
      logic [7:0] data;
      logic       full;
      logic       empty;
      logic       afull;
      logic       ovf;
      logic       udf;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] mq[$];
   logic       m_ovf = 1'b0;
   logic       m_udf = 1'b0;
   int         checks = 0;
   int         fails  = 0;
   logic [7:0] mon_out = 8'h00;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Drive one cycle of stimulus and record what the FIFO must show after the edge.
   task automatic step(input logic r, input logic e, input logic w, input logic rd,
                       input logic [7:0] d);
      exp_t x;
      logic is_full, is_empty, do_pop, do_push;
      @(negedge clk);
      rst_n  = r;
      ena    = e;
      uio_in = {6'b0, rd, w};
      ui_in  = d;
      x.has_data = 1'b0;
      x.data     = 8'h00;
      if (r) begin
         mq.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
         x.has_data = 1'b1;
      end else if (e) begin
         is_full  = (mq.size() == 16);
         is_empty = (mq.size() == 0);
         do_pop   = rd && !is_empty;
         do_push  = w && (!is_full || do_pop);
         if (w && !do_push) m_ovf = 1'b1;
         if (rd && is_empty) m_udf = 1'b1;
         if (do_pop) begin
            x.has_data = 1'b1;
            x.data     = mq.pop_front();
         end
         if (do_push) mq.push_back(d);
      end
      x.full  = (mq.size() == 16);
      x.empty = (mq.size() == 0);
      x.afull = (mq.size() >= 14);
      x.ovf   = m_ovf;
      x.udf   = m_udf;
      exp_q.push_back(x);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (e.has_data) mon_out = e.data;
         check("uo_out", uo_out, mon_out);
         check("full", {7'b0, uio_out[2]}, {7'b0, e.full});
         check("empty", {7'b0, uio_out[3]}, {7'b0, e.empty});
         check("almost_full", {7'b0, uio_out[4]}, {7'b0, e.afull});
         check("overflow", {7'b0, uio_out[5]}, {7'b0, e.ovf});
         check("underflow", {7'b0, uio_out[6]}, {7'b0, e.udf});
         check("uio_out_reserved", {uio_out[7], 5'b0, uio_out[1:0]}, 8'h00);
      end
   end

   initial begin
      rst_n  = 1'b1;
      ena    = 1'b0;
      ui_in  = 8'h00;
      uio_in = 8'h00;

      // Reset, with a write strobe that reset must override
      step(1, 1, 1, 0, 8'h77);
      step(1, 1, 0, 0, 8'h00);
      check("uio_oe", uio_oe, 8'h7C);

      // Disabled tile ignores writes
      repeat (3) step(0, 0, 1, 0, 8'hA5);

      // Basic ordering and one-cycle read latency
      step(0, 1, 1, 0, 8'h11);
      step(0, 1, 1, 0, 8'h22);
      step(0, 1, 1, 0, 8'h33);
      repeat (3) step(0, 1, 0, 1, 8'h00);
      step(0, 1, 0, 0, 8'h00);

      // Fill, overflow attempt, drain
      for (int i = 0; i < 16; i++) step(0, 1, 1, 0, 8'(i));
      step(0, 1, 1, 0, 8'hEE);
      for (int i = 0; i < 16; i++) step(0, 1, 0, 1, 8'h00);

      // Full with simultaneous push+pop, wrapping pointers
      for (int i = 0; i < 16; i++) step(0, 1, 1, 0, 8'(8'h40 + i));
      for (int i = 0; i < 20; i++) step(0, 1, 1, 1, 8'(8'h5A + i));
      for (int i = 0; i < 16; i++) step(0, 1, 0, 1, 8'h00);

      // Underflow, simultaneous push+pop on empty, then reset mid-stream
      step(0, 1, 0, 1, 8'h00);
      step(0, 1, 1, 1, 8'hC3);
      for (int i = 0; i < 17; i++) step(0, 1, 1, 0, 8'(8'h80 + i));
      step(1, 1, 1, 0, 8'hF0);
      step(0, 1, 1, 0, 8'hF1);
      step(0, 1, 0, 1, 8'h00);

      // Randomized traffic with write-heavy then read-heavy phases
      for (int i = 0; i < 600; i++) begin
         logic w, rd, e, r;
         int wp;
         wp = (i < 300) ? 70 : 35;
         w  = ($urandom_range(99) < wp);
         rd = ($urandom_range(99) < (100 - wp));
         e  = ($urandom_range(99) < 90);
         r  = ($urandom_range(199) == 0);
         step(r, e, w, rd, 8'($urandom));
      end

      step(0, 1, 0, 0, 8'h00);
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
